// File: rtl/histo_pkg.sv
// Shared state encoding and default sizes for the histogram readout path.
package histo_pkg;

  localparam int unsigned HISTO_BIN_W  = 10;
  localparam int unsigned HISTO_NBINS  = 1024;
  localparam int unsigned HISTO_DATA_W = 24;
  localparam int unsigned HISTO_TX_W   = HISTO_BIN_W + HISTO_DATA_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_ACCUM   = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_WAIT = 3'd4,
    S_SEND    = 3'd5,
    S_CLEAR   = 3'd6
  } histo_state_e;

endpackage

// File: rtl/histo_readout_ctrl_frame_edge_det.sv
// Rise/fall detector for the synchronous sensor frame gate.
module frame_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic frame_valid,
  output logic rise_c,
  output logic fall_c
);

  logic fv_d;
  logic primed;

  // First sample after reset only primes fv_d, so a gate already high is not a rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      fv_d   <= 1'b0;
      primed <= 1'b0;
    end else begin
      fv_d   <= frame_valid;
      primed <= 1'b1;
    end
  end

  assign rise_c = primed & frame_valid & ~fv_d;
  assign fall_c = primed & ~frame_valid & fv_d;

endmodule

// File: rtl/histo_readout_ctrl.sv
// Frame-gated histogram sequencer: accumulate one frame, stream every bin, then clear the RAM.
module histo_readout_ctrl
  import histo_pkg::*;
#(
  parameter int unsigned BIN_W  = HISTO_BIN_W,
  parameter int unsigned NBINS  = HISTO_NBINS,
  parameter int unsigned DATA_W = HISTO_DATA_W,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    frame_valid,
  input  logic [DATA_W-1:0]       rd_data,
  output logic [BIN_W-1:0]        bin,
  output logic                    hist_accum_en,
  output logic                    hist_clr,
  output logic [BIN_W+DATA_W-1:0] tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    tx_last,
  output logic                    busy,
  output logic [15:0]             frames_dropped,
  output logic [2:0]              state_dbg
);

  localparam int unsigned LAT_W  = 2;
  localparam int unsigned DROP_W = 16;
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NBINS - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT - 1);

  histo_state_e     state;
  histo_state_e     state_nxt;
  logic [LAT_W-1:0] lat_cnt;
  logic             rise_c;
  logic             fall_c;
  logic             last_bin_c;
  logic             drop_c;

  frame_edge_det u_edge (
    .clk        (clk),
    .reset      (reset),
    .frame_valid(frame_valid),
    .rise_c     (rise_c),
    .fall_c     (fall_c)
  );

  assign last_bin_c = (bin == LAST_BIN);
  assign drop_c     = rise_c & (state inside {S_RD_ADDR, S_RD_WAIT, S_SEND, S_CLEAR});

  // Gate opens in the rise cycle itself so the first line of pixels is counted.
  assign hist_accum_en = ((state == S_ARMED) & rise_c) | ((state == S_ACCUM) & frame_valid);

  // Next-state decision.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (enable) state_nxt = S_ARMED;
      S_ARMED:   if (rise_c) state_nxt = S_ACCUM;
      S_ACCUM:   if (fall_c) state_nxt = S_RD_ADDR;
      S_RD_ADDR: state_nxt = S_RD_WAIT;
      S_RD_WAIT: if (lat_cnt == '0) state_nxt = S_SEND;
      S_SEND:    if (tx_ready) state_nxt = last_bin_c ? S_CLEAR : S_RD_ADDR;
      S_CLEAR:   if (hist_clr && last_bin_c) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State register, bin walk, read-latency counter and tx register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_CLEAR;
      bin            <= '0;
      lat_cnt        <= '0;
      hist_clr       <= 1'b0;
      tx_data        <= '0;
      tx_valid       <= 1'b0;
      tx_last        <= 1'b0;
      busy           <= 1'b0;
      frames_dropped <= '0;
      state_dbg      <= '0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != S_IDLE);
      state_dbg <= state_nxt;

      if (drop_c && (frames_dropped != '1)) frames_dropped <= frames_dropped + DROP_W'(1);

      unique case (state)
        S_ACCUM: if (fall_c) bin <= '0;
        S_RD_ADDR: lat_cnt <= LAT_LOAD;
        S_RD_WAIT: begin
          if (lat_cnt == '0) begin
            tx_data  <= {bin, rd_data};
            tx_valid <= 1'b1;
            tx_last  <= last_bin_c;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            if (last_bin_c) begin
              bin      <= '0;
              hist_clr <= 1'b1;
            end else begin
              bin <= bin + BIN_W'(1);
            end
          end
        end
        // Coming out of reset, hist_clr is low: spend one cycle raising it before walking.
        S_CLEAR: begin
          if (!hist_clr) begin
            hist_clr <= 1'b1;
          end else if (last_bin_c) begin
            hist_clr <= 1'b0;
            bin      <= '0;
          end else begin
            bin <= bin + BIN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_histo_readout_ctrl.sv
// Directed bench for histo_readout_ctrl with a transaction-level output model (NBINS=8, RD_LAT=2).
module tb_histo_readout_ctrl;
  import histo_pkg::*;

  localparam int unsigned BIN_W  = 10;
  localparam int unsigned NBINS  = 8;
  localparam int unsigned DATA_W = 24;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned TX_W   = BIN_W + DATA_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic              frame_valid = 1'b0;
  logic              tx_ready = 1'b1;
  logic [DATA_W-1:0] rd_data;
  logic [BIN_W-1:0]  bin;
  logic              hist_accum_en;
  logic              hist_clr;
  logic [TX_W-1:0]   tx_data;
  logic              tx_valid;
  logic              tx_last;
  logic              busy;
  logic [15:0]       frames_dropped;
  logic [2:0]        state_dbg;

  histo_readout_ctrl #(
    .BIN_W(BIN_W), .NBINS(NBINS), .DATA_W(DATA_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_valid(frame_valid),
    .rd_data(rd_data), .bin(bin), .hist_accum_en(hist_accum_en), .hist_clr(hist_clr),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .busy(busy), .frames_dropped(frames_dropped), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // RAM model: two-cycle read latency, contents bin*3.
  logic [BIN_W-1:0] bin_q1, bin_q2;
  always @(posedge clk) begin
    bin_q1 <= bin;
    bin_q2 <= bin_q1;
  end
  assign rd_data = DATA_W'(bin_q2) * DATA_W'(3);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model state: which frame may accumulate, next expected word, clear-walk index.
  bit              chk_on = 0;
  bit              exp_accum = 0;
  int              exp_word = 0;
  int              clr_idx = 0;
  int              clr_cycles = 0;
  int              accum_cycles = 0;
  int              last_cnt = 0;
  int              cyc = 0;
  int              last_hs_cyc = 0;
  bit              stall_seen = 0;
  bit              prev_hold = 0;
  bit              prev_hs = 0;
  bit              prev_rst = 1;
  logic [TX_W-1:0] got_words[$];

  always @(negedge clk) begin
    cyc++;
    if (chk_on) begin
      check("accum_en", hist_accum_en, exp_accum & frame_valid);
      if (hist_accum_en) accum_cycles++;
      if (!prev_rst) begin
        if (prev_hold) check("valid_hold", tx_valid, 1'b1);
        if (prev_hs) check("valid_drop", tx_valid, 1'b0);
      end
      if (!tx_valid) check("last_wo_valid", tx_last, 1'b0);
      if (tx_valid) begin
        check("tx_data", tx_data, {BIN_W'(exp_word), DATA_W'(exp_word * 3)});
        check("tx_last", tx_last, exp_word == NBINS - 1);
        if (!tx_ready) begin
          stall_seen = 1;
        end else begin
          if (exp_word != 0 && !stall_seen) check("word_gap", cyc - last_hs_cyc, RD_LAT + 2);
          got_words.push_back(tx_data);
          if (tx_last) last_cnt++;
          exp_word++;
          stall_seen  = 0;
          last_hs_cyc = cyc;
        end
      end
      if (hist_clr) begin
        check("clr_bin", bin, clr_idx);
        clr_idx = (clr_idx + 1) % NBINS;
        clr_cycles++;
      end
    end
    prev_hold = tx_valid & ~tx_ready;
    prev_hs   = tx_valid & tx_ready;
    prev_rst  = reset;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    while (busy && c < 300) begin
      tick();
      c++;
    end
    if (busy) timeout_fail(name);
  endtask

  task automatic new_frame();
    exp_word     = 0;
    got_words.delete();
    last_cnt     = 0;
    accum_cycles = 0;
    clr_cycles   = 0;
  endtask

  task automatic arm();
    enable = 1'b1;
    tick();
    check("armed_state", state_dbg, S_ARMED);
    check("armed_busy", busy, 1'b1);
    enable = 1'b0;
    tick(2);
  endtask

  task automatic accum_frame(input int len);
    exp_accum   = 1;
    frame_valid = 1'b1;
    tick(len);
    frame_valid = 1'b0;
    exp_accum   = 0;
  endtask

  initial begin
    int c;

    // Reset values, then the power-up clear walk.
    tick();
    chk_on = 1;
    tick(2);
    check("rst_bin", bin, 0);
    check("rst_hist_clr", hist_clr, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_dropped", frames_dropped, 0);
    check("rst_state", state_dbg, 0);
    reset = 1'b0;
    clr_cycles = 0;
    tick();
    check("clr_start", {busy, hist_clr, bin}, {1'b1, 1'b1, 10'd0});
    check("clr_state", state_dbg, S_CLEAR);
    c = 0;
    while (busy && c < 50) begin
      c++;
      tick();
    end
    check("pwrup_busy_cycles", c, 8);
    check("pwrup_clr_cycles", clr_cycles, 8);
    check("pwrup_idle", state_dbg, S_IDLE);

    // Full frame: 100-cycle gate, eight words, clear.
    new_frame();
    arm();
    accum_frame(100);
    wait_idle("frame1_idle");
    check("f1_accum_cycles", accum_cycles, 100);
    check("f1_word_count", got_words.size(), 8);
    if (got_words.size() == 8) begin
      check("f1_word1", got_words[1], {10'd1, 24'd3});
      check("f1_word7", got_words[7], {10'd7, 24'd21});
    end
    check("f1_last_cnt", last_cnt, 1);
    check("f1_clr_cycles", clr_cycles, 8);

    // Back-pressure on the bin-3 word.
    new_frame();
    arm();
    accum_frame(10);
    c = 0;
    while (bin != 10'd3 && c < 100) begin
      tick();
      c++;
    end
    if (bin != 10'd3) timeout_fail("stall_bin3");
    tx_ready = 1'b0;
    tick(20);
    check("stall_valid", tx_valid, 1'b1);
    check("stall_bin", bin, 3);
    check("stall_data", tx_data, {10'd3, 24'd9});
    tx_ready = 1'b1;
    wait_idle("stall_idle");
    check("stall_word_count", got_words.size(), 8);
    check("stall_last_cnt", last_cnt, 1);

    // Rises during SEND and CLEAR are dropped.
    new_frame();
    arm();
    accum_frame(6);
    c = 0;
    while (!tx_valid && c < 50) begin
      tick();
      c++;
    end
    if (!tx_valid) timeout_fail("drop_send_wait");
    frame_valid = 1'b1;
    tick(3);
    frame_valid = 1'b0;
    c = 0;
    while (!hist_clr && c < 100) begin
      tick();
      c++;
    end
    if (!hist_clr) timeout_fail("drop_clear_wait");
    frame_valid = 1'b1;
    tick(3);
    frame_valid = 1'b0;
    wait_idle("drop_idle");
    check("drop_count", frames_dropped, 2);
    check("drop_word_count", got_words.size(), 8);

    // enable and rise together in IDLE: arm only, frame missed and not counted.
    enable      = 1'b1;
    frame_valid = 1'b1;
    tick();
    enable = 1'b0;
    check("simul_armed", state_dbg, S_ARMED);
    tick(3);
    frame_valid = 1'b0;
    tick(2);
    check("simul_dropped", frames_dropped, 2);
    new_frame();
    accum_frame(5);
    wait_idle("simul_idle");
    check("simul_accum_cycles", accum_cycles, 5);
    check("simul_word_count", got_words.size(), 8);

    // Reset while the bin-5 word is pending.
    new_frame();
    arm();
    accum_frame(4);
    c = 0;
    while (!(tx_valid && bin == 10'd5) && c < 100) begin
      tick();
      c++;
    end
    if (!(tx_valid && bin == 10'd5)) timeout_fail("rst_send_wait");
    reset    = 1'b1;
    tx_ready = 1'b0;
    tick();
    check("mid_rst_outputs",
          {bin, hist_clr, hist_accum_en, tx_valid, tx_last, busy, state_dbg, frames_dropped}, 0);
    check("mid_rst_tx_data", tx_data, 0);
    check("mid_rst_words", got_words.size(), 5);
    reset    = 1'b0;
    tx_ready = 1'b1;
    clr_idx  = 0;
    clr_cycles = 0;
    exp_word = 0;
    tick();
    check("mid_rst_clr_start", {hist_clr, bin}, {1'b1, 10'd0});
    wait_idle("mid_rst_idle");
    check("mid_rst_clr_cycles", clr_cycles, 8);
    check("mid_rst_last_cnt", last_cnt, 0);

    // Gate already high at reset release: no accumulation until a fresh rise.
    exp_accum   = 0;
    frame_valid = 1'b1;
    enable      = 1'b1;
    reset       = 1'b1;
    tick(2);
    reset = 1'b0;
    tick();
    wait_idle("hi_rst_idle");
    tick(3);
    enable = 1'b0;
    check("hi_rst_armed", state_dbg, S_ARMED);
    check("hi_rst_dropped", frames_dropped, 0);
    frame_valid = 1'b0;
    tick(2);
    new_frame();
    accum_frame(4);
    wait_idle("hi_rst_frame_idle");
    check("hi_rst_accum_cycles", accum_cycles, 4);
    check("hi_rst_word_count", got_words.size(), 8);
    check("hi_rst_dropped_end", frames_dropped, 0);

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
